// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmit controller.
package piso_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_ser.sv
// Load/shift register feeding one serial bit; 0 fills in behind the outgoing bit.
module shift_reg_ser #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ser_bit
);

  logic [DATA_W-1:0] r_sr;

  // Clear outranks load, which outranks shift, so a cancel always wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      if (MSB_FIRST != 0) r_sr <= {r_sr[DATA_W-2:0], 1'b0};
      else                r_sr <= {1'b0, r_sr[DATA_W-1:1]};
    end
  end

  assign o_ser_bit = (MSB_FIRST != 0) ? r_sr[DATA_W-1] : r_sr[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Frame controller: accepts a parallel word in IDLE, shifts it out one bit per
// tick, pulses done for one cycle after the last bit.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              tick,
  input  logic              abort,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic w_load;
  logic w_shift;
  logic w_ser_bit;

  assign w_load  = (r_state == ST_IDLE)  && in_valid && !abort;
  assign w_shift = (r_state == ST_SHIFT) && tick && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (in_valid) begin
              r_state <= ST_SHIFT;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (tick) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == LAST_CNT) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  shift_reg_ser #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg_ser (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_clear   (abort),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_data    (in_data),
    .o_ser_bit (w_ser_bit)
  );

  // The register is already empty outside SHIFT; gating keeps the line quiet regardless.
  assign ser_out   = w_ser_bit && (r_state == ST_SHIFT);
  assign ser_valid = w_shift;
  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a queue-based model of the frame.
module tb_piso_tx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          tick = 1'b0;
  logic          abort = 1'b0;

  logic rdy_m, so_m, sv_m, busy_m, done_m;
  logic rdy_l, so_l, sv_l, busy_l, done_l;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.DATA_W(DW), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_m), .tick(tick), .abort(abort), .ser_out(so_m),
    .ser_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  piso_tx_ctrl #(.DATA_W(DW), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_l), .tick(tick), .abort(abort), .ser_out(so_l),
    .ser_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: remaining bits of the frame in transmit order, plus a done-cycle flag.
  bit q_m[$];
  bit q_l[$];
  bit done_now = 1'b0;

  bit cap_m[$];
  bit cap_l[$];
  int n_valid = 0;
  int n_done = 0;
  int xfer_cyc_q[$];
  int done_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_idle();
    return (q_m.size() == 0) && !done_now;
  endfunction

  task automatic model_reset();
    q_m.delete();
    q_l.delete();
    done_now = 1'b0;
  endtask

  task automatic check_outputs();
    bit in_frame;
    in_frame = (q_m.size() > 0);
    chk("in_ready_m",  rdy_m,  model_idle());
    chk("in_ready_l",  rdy_l,  model_idle());
    chk("busy_m",      busy_m, in_frame);
    chk("busy_l",      busy_l, in_frame);
    chk("done_m",      done_m, done_now);
    chk("done_l",      done_l, done_now);
    chk("ser_valid_m", sv_m,   in_frame && tick && !abort);
    chk("ser_valid_l", sv_l,   in_frame && tick && !abort);
    chk("ser_out_m",   so_m,   in_frame ? q_m[0] : 1'b0);
    chk("ser_out_l",   so_l,   in_frame ? q_l[0] : 1'b0);
    if (sv_m) begin cap_m.push_back(so_m); n_valid++; end
    if (sv_l) cap_l.push_back(so_l);
    if (done_m) begin n_done++; done_cyc_q.push_back(cyc); end
  endtask

  task automatic model_edge();
    if (abort) begin
      model_reset();
    end else if (q_m.size() > 0) begin
      if (tick) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
        if (q_m.size() == 0) done_now = 1'b1;
      end
    end else if (done_now) begin
      done_now = 1'b0;
    end else if (in_valid) begin
      for (int i = DW - 1; i >= 0; i--) q_m.push_back(in_data[i]);
      for (int i = 0; i < DW; i++) q_l.push_back(in_data[i]);
      xfer_cyc_q.push_back(cyc);
    end
  endtask

  task automatic do_cycle(input bit v, input logic [DW-1:0] d, input bit t, input bit a);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    tick     = t;
    abort    = a;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
  endtask

  task automatic clear_caps();
    cap_m.delete();
    cap_l.delete();
    n_valid = 0;
    n_done = 0;
    xfer_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  function automatic logic [31:0] pack(input bit which_lsb);
    logic [31:0] v;
    v = '0;
    if (which_lsb) foreach (cap_l[i]) v = {v[30:0], cap_l[i]};
    else           foreach (cap_m[i]) v = {v[30:0], cap_m[i]};
    return v;
  endfunction

  // Offer a word, then tick every 'per' cycles until the frame has fully drained.
  task automatic run_frame(input logic [DW-1:0] w, input int per);
    do_cycle(1'b1, w, per == 1, 1'b0);
    for (int i = 1; i < 200 && !model_idle(); i++)
      do_cycle(1'b0, '0, (i % per) == 0, 1'b0);
  endtask

  initial begin
    int gap;

    // Reset asserted between edges
    #2 rst = 1'b0;
    #1;
    chk("rst_ser_out",   so_m,   1'b0);
    chk("rst_ser_valid", sv_m,   1'b0);
    chk("rst_busy",      busy_m, 1'b0);
    chk("rst_done",      done_m, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready",  rdy_m,  1'b1);

    // 0x55 at full rate
    clear_caps();
    run_frame(8'h55, 1);
    #1;
    chk("f55_bits",      pack(1'b0), 32'h55);
    chk("f55_nvalid",    n_valid, 8);
    chk("f55_ndone",     n_done, 1);
    gap = (done_cyc_q.size() == 1 && xfer_cyc_q.size() == 1) ? done_cyc_q[0] - xfer_cyc_q[0] : -1;
    chk("f55_done_lat",  gap, 9);
    chk("f55_ready_after", rdy_m, 1'b1);
    do_cycle(1'b0, '0, 1'b1, 1'b0);

    // 0xA3 with a tick every 4th cycle
    clear_caps();
    run_frame(8'hA3, 4);
    chk("fA3_bits_m",    pack(1'b0), 32'hA3);
    chk("fA3_bits_l",    pack(1'b1), 32'hC5);
    chk("fA3_nvalid",    n_valid, 8);
    chk("fA3_ndone",     n_done, 1);

    // 0x01: LSB-first instance emits the 1 first
    clear_caps();
    run_frame(8'h01, 1);
    chk("f01_bits_l",    pack(1'b1), 32'h80);
    chk("f01_bits_m",    pack(1'b0), 32'h01);
    chk("f01_ndone",     n_done, 1);

    // Abort in IDLE blocks the offered word
    clear_caps();
    do_cycle(1'b1, 8'h99, 1'b1, 1'b1);
    #1;
    chk("abort_idle_ready", rdy_m, 1'b1);
    chk("abort_idle_busy",  busy_m, 1'b0);
    chk("abort_idle_xfer",  xfer_cyc_q.size(), 0);

    // 0xFF aborted after three bits, then 0x0F
    clear_caps();
    do_cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    repeat (3) do_cycle(1'b0, '0, 1'b1, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b1);
    #1;
    chk("abort_ser_out",  so_m, 1'b0);
    chk("abort_ready",    rdy_m, 1'b1);
    chk("abort_nvalid",   n_valid, 3);
    repeat (3) do_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("abort_ndone",    n_done, 0);
    clear_caps();
    run_frame(8'h0F, 1);
    chk("f0F_bits_m",     pack(1'b0), 32'h0F);
    chk("f0F_ndone",      n_done, 1);

    // Asynchronous reset mid-frame, then 0x81
    clear_caps();
    do_cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    repeat (3) do_cycle(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy",    busy_m, 1'b0);
    chk("midrst_ser_out", so_m, 1'b0);
    chk("midrst_ser_vld", sv_m, 1'b0);
    chk("midrst_done",    done_m, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) do_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("midrst_ndone",   n_done, 0);
    clear_caps();
    run_frame(8'h81, 1);
    chk("f81_bits_m",     pack(1'b0), 32'h81);
    chk("f81_bits_l",     pack(1'b1), 32'h81);
    chk("f81_ndone",      n_done, 1);

    // Back-to-back words with in_valid held high
    clear_caps();
    for (int k = 0; k < 40 && xfer_cyc_q.size() < 1; k++) do_cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    for (int k = 0; k < 40 && xfer_cyc_q.size() < 2; k++) do_cycle(1'b1, 8'hC3, 1'b1, 1'b0);
    for (int k = 0; k < 40 && !model_idle(); k++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("b2b_bits",   pack(1'b0), 32'h3CC3);
    chk("b2b_nvalid", n_valid, 16);
    chk("b2b_ndone",  n_done, 2);
    gap = (xfer_cyc_q.size() == 2 && done_cyc_q.size() >= 1) ? xfer_cyc_q[1] - done_cyc_q[0] : -1;
    chk("b2b_gap",    gap, 1);

    // Random traffic: sporadic offers, irregular ticks, occasional aborts
    clear_caps();
    for (int k = 0; k < 600; k++)
      do_cycle(($urandom % 3) == 0, DW'($urandom), ($urandom % 4) != 0, ($urandom % 60) == 0);
    repeat (30) do_cycle(1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
